// File: rtl/sub8_diff_accumulator.sv
// Frame accumulator for the 8-bit signed subtractor stream: sums N_SAMPLES differences,
// counts overflow flags, and hands the total downstream. Define SUB8_ACC_SAT_EN to clamp the sum.
module sub8_diff_accumulator #(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 16,
  parameter int OVC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       result,
  input  logic             overflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic [OVC_W-1:0] ovf_count,
  output logic             sat_flag
);

  typedef enum logic {ACCUM, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       cnt_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [OVC_W-1:0] ovc_q;
  logic             sat_q;
  logic             clip;
  logic             accept, handoff, last;

  assign last    = (cnt_q == LAST_CNT);
  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

`ifdef SUB8_ACC_SAT_EN
  // One guard bit: disagreement between the top two bits means the true sum left the ACC_W range.
  logic [ACC_W:0] wide;
  assign wide = {acc_q[ACC_W-1], acc_q} + {{(ACC_W-7){result[7]}}, result};

  always_comb begin
    clip  = 1'b0;
    acc_d = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      clip  = 1'b1;
      acc_d = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end
`else
  assign acc_d = acc_q + {{(ACC_W-8){result[7]}}, result};
  assign clip  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      ovc_q <= '0;
      sat_q <= 1'b0;
      cnt_q <= '0;
    end else if (handoff) begin
      acc_q <= '0;
      ovc_q <= '0;
      sat_q <= 1'b0;
    end else if (accept) begin
      acc_q <= acc_d;
      if (overflow && (ovc_q != '1)) ovc_q <= ovc_q + 1'b1;
      if (clip) sat_q <= 1'b1;
      cnt_q <= last ? '0 : cnt_q + 8'd1;
    end
  end

  assign sum       = acc_q;
  assign ovf_count = ovc_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_sub8_diff_accumulator.sv
// Directed bench for sub8_diff_accumulator: a default-width instance and an ACC_W=10 instance
// share one stimulus stream; narrow expectations follow SUB8_ACC_SAT_EN.
module tb_sub8_diff_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  result;
  logic        overflow;
  logic        out_ready;

  logic        in_ready, out_valid, sat_flag;
  logic [15:0] sum;
  logic [7:0]  ovf_count;

  logic        n_in_ready, n_out_valid, n_sat_flag;
  logic [9:0]  n_sum;
  logic [7:0]  n_ovf_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sub8_diff_accumulator #(.N_SAMPLES(8), .ACC_W(16), .OVC_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .result(result), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .ovf_count(ovf_count), .sat_flag(sat_flag)
  );

  sub8_diff_accumulator #(.N_SAMPLES(8), .ACC_W(10), .OVC_W(8)) dut_n (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .result(result), .overflow(overflow), .out_valid(n_out_valid),
    .out_ready(out_ready), .sum(n_sum), .ovf_count(n_ovf_count), .sat_flag(n_sat_flag)
  );

  // Present one sample at the falling edge; it is taken on the following rising edge.
  task automatic send(input logic [7:0] r, input logic o);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
    end
    in_valid = 1'b1;
    result   = r;
    overflow = o;
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    overflow = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; result = '0; overflow = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (sum !== 16'd0 || ovf_count !== 8'd0 || sat_flag !== 1'b0 ||
        out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: sum=%0d ovf=%0d sat=%b ov=%b ir=%b required 0 0 0 0 1",
               sum, ovf_count, sat_flag, out_valid, in_ready);
    end
  endtask

  task automatic test_max_positive();
    logic [9:0] n_exp;
    logic       n_sat;
`ifdef SUB8_ACC_SAT_EN
    n_exp = 10'd511;  n_sat = 1'b1;
`else
    n_exp = 10'h3F8;  n_sat = 1'b0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'd127, 1'b0);
    idle();
    total++;
    if (out_valid !== 1'b1 || sum !== 16'd1016 || ovf_count !== 8'd0 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL max_pos_frame: ov=%b sum=%0d ovf=%0d sat=%b required 1 1016 0 0",
               out_valid, sum, ovf_count, sat_flag);
    end
    total++;
    if (n_out_valid !== 1'b1 || n_sum !== n_exp || n_sat_flag !== n_sat) begin
      bad++;
      $display("FAIL narrow_width: ov=%b sum=%h sat=%b required 1 %h %b",
               n_out_valid, n_sum, n_sat_flag, n_exp, n_sat);
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'd0 || n_sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL after_handoff: ov=%b ir=%b sum=%0d nsat=%b required 0 1 0 0",
               out_valid, in_ready, sum, n_sat_flag);
    end
  endtask

  task automatic test_overflow_count();
    logic [15:0] exp_sum;
    exp_sum = -16'sd1024;
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send(8'h80, (i == 2 || i == 5 || i == 7));
    idle();
    total++;
    if (out_valid !== 1'b1 || sum !== exp_sum || ovf_count !== 8'd3) begin
      bad++;
      $display("FAIL min_neg_ovf: ov=%b sum=%h ovf=%0d required 1 %h 3",
               out_valid, sum, ovf_count, exp_sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (ovf_count !== 8'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovf_clear: ovf=%0d ov=%b required 0 0", ovf_count, out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(8'd5, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; result = 8'd100;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || sum !== 16'd40 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d: ov=%b sum=%0d ir=%b required 1 40 0", i, out_valid, sum, in_ready);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || sum !== 16'd0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_handoff: ov=%b sum=%0d ir=%b required 0 0 1", out_valid, sum, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (sum !== 16'd100) begin
      bad++;
      $display("FAIL bp_new_frame: sum=%0d required 100", sum);
    end
    for (int i = 0; i < 7; i++) send(8'd0, 1'b0);
    idle();
    total++;
    if (out_valid !== 1'b1 || sum !== 16'd100) begin
      bad++;
      $display("FAIL bp_frame_end: ov=%b sum=%0d required 1 100", out_valid, sum);
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'd10, 1'b0);
    idle();
    #2 rst = 1'b1;
    #1;
    total++;
    if (sum !== 16'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL async_reset: sum=%0d ov=%b ir=%b required 0 0 1", sum, out_valid, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) send(8'd1, 1'b0);
    idle();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_partial: ov=%b required 0 after 7 accepts", out_valid);
    end
    send(8'd1, 1'b0);
    idle();
    total++;
    if (out_valid !== 1'b1 || sum !== 16'd8) begin
      bad++;
      $display("FAIL reset_refill: ov=%b sum=%0d required 1 8", out_valid, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_gapped();
    logic [15:0] exp_sum;
    exp_sum = -16'sd8;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'hFF, 1'b0);
      idle();
      if (i == 6) begin
        total++;
        if (out_valid !== 1'b0 || sum !== -16'sd7) begin
          bad++;
          $display("FAIL gap_partial: ov=%b sum=%0d required 0 -7", out_valid, $signed(sum));
        end
      end
    end
    total++;
    if (out_valid !== 1'b1 || sum !== exp_sum) begin
      bad++;
      $display("FAIL gap_frame: ov=%b sum=%h required 1 %h", out_valid, sum, exp_sum);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_max_positive();
    test_overflow_count();
    test_backpressure();
    test_async_reset();
    test_gapped();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sub8_diff_accumulator.md
Name: sub8_diff_accumulator

Overview:
- Consumes the stream of 8-bit signed differences (result, overflow) produced by the 8-bit signed subtractor stage.
- Accumulates a frame of N_SAMPLES differences into a wide signed sum.
- Counts how many samples in the frame carried overflow=1.
- Presents the frame total on a valid/ready output interface to the downstream statistics/reporting logic.

Parameters:
- N_SAMPLES, 8: samples per frame; legal range 1..255.
- ACC_W, 16: accumulator width in bits, signed; legal range 9..32.
- OVC_W, 8: width of the overflow counter; saturates at 2^OVC_W-1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream difference sample is present.
- in_ready  output  1  block accepts a sample this cycle.
- result  input  8  signed difference from the subtractor (two's complement).
- overflow  input  1  subtractor overflow flag for this sample.
- out_valid  output  1  frame total is available.
- out_ready  input  1  downstream consumes the frame total.
- sum  output  ACC_W  signed frame sum.
- ovf_count  output  OVC_W  number of accepted samples with overflow=1.
- sat_flag  output  1  accumulator clipped at least once in this frame.

Behaviour:
- Reset (async, any time): state=ACCUM, sum=0, ovf_count=0, sat_flag=0, sample counter=0, out_valid=0, in_ready=1.
- Reset mid-frame discards the partial frame. The next frame needs a full N_SAMPLES accepts.
- FSM has two states.
  - ACCUM: in_ready=1, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: a sample is taken on a clock edge where in_valid && in_ready.
- On each accept in ACCUM:
  - sum <= sum + sign_extend(result) to ACC_W bits (see Optional Feature for range handling).
  - ovf_count increments if overflow=1; holds at its max value, never wraps.
  - Sample counter increments.
- On the accept where the counter equals N_SAMPLES-1:
  - The sum/ovf/sat update still occurs.
  - Counter clears to 0.
  - State becomes DONE.
  - out_valid rises the cycle after the Nth accept (latency 1).
- DONE:
  - sum, ovf_count and sat_flag hold stable while out_valid=1 && !out_ready.
  - in_valid is ignored and no sample is consumed.
- Handshake in DONE: on out_valid && out_ready, next cycle sum=0, ovf_count=0, sat_flag=0, state=ACCUM.
  - The cycle after a handoff is the earliest cycle a new sample can be accepted (one bubble).
- The overflow input is counted only. The wrapped 8-bit result value is summed as given; it is never corrected.
- N_SAMPLES=1: every accept moves directly to DONE.
- in_valid may be deasserted between samples; partial-frame state holds indefinitely.
- out_ready while in ACCUM has no effect.

Optional Feature:
- Macro: SUB8_ACC_SAT_EN.
- Defined:
  - The addition is computed at ACC_W+1 bits.
  - Results above 2^(ACC_W-1)-1 clamp to that value; results below -2^(ACC_W-1) clamp to that value.
  - sat_flag sets on any clamp and is sticky until the frame handoff or reset.
- Not defined:
  - Sum wraps modulo 2^ACC_W.
  - sat_flag is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Default params; 8 accepts of result=127, overflow=0, out_ready=1 → one cycle after the 8th accept: out_valid=1, sum=1016, ovf_count=0, sat_flag=0; next cycle out_valid=0, in_ready=1, sum=0.
- Default params; 8 accepts of result=-128 with overflow=1 on samples 2, 5, 7 → sum=-1024, ovf_count=3.
- ACC_W=10; 8 accepts of result=127:
  - With SUB8_ACC_SAT_EN: sum=511, sat_flag=1.
  - Without it: sum=-8, sat_flag=0.
- Frame complete with out_ready held low 5 cycles while in_valid=1:
  - out_valid stays 1, sum unchanged, in_ready=0, no sample consumed.
  - out_ready=1 → handoff; the next accept starts a new frame.
- Assert rst asynchronously after 4 accepts of result=10 → outputs zero immediately; then 8 accepts of result=1 → sum=8, not 48.
- Gapped input with in_valid toggling every other cycle over 8 accepts of result=-1 → sum=-8; out_valid one cycle after the 8th accept.
